// File: rtl/hdlc_tx_arbiter.sv
// rtl/hdlc_tx_arbiter.sv - round-robin loader of two frame sources into the HDLC Tx buffer
// Optional per-requester frame abort: define HDLC_TX_ARB_ABORT_EN.
module hdlc_tx_arbiter #(
    parameter int MAX_FRAME = 126
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Req0_Valid,
    input  logic [7:0] Req0_Data,
    input  logic       Req0_Last,
    input  logic       Req0_Abort,
    output logic       Req0_Ready,
    input  logic       Req1_Valid,
    input  logic [7:0] Req1_Data,
    input  logic       Req1_Last,
    input  logic       Req1_Abort,
    output logic       Req1_Ready,
    output logic [1:0] Grant,
    output logic [7:0] Tx_DataInBuff,
    output logic       Tx_WrBuff,
    output logic       Tx_Enable,
    output logic       Tx_AbortFrame,
    input  logic       Tx_Full,
    input  logic       Tx_Done,
    output logic       Overlong
);
    localparam logic [7:0] MAX_CNT = 8'(MAX_FRAME);

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, START, WAIT_DONE} state_t;

    state_t     state, state_nxt;
    logic [1:0] grant_nxt;
    logic       ptr, ptr_nxt;
    logic [7:0] count, count_nxt;
    logic [7:0] data_nxt;
    logic       wr_nxt, en_nxt, abort_nxt, ovl_nxt;
    logic       low_seen, low_seen_nxt;
    logic       sel_valid, sel_last, sel_abort, ready, hs;
    logic [7:0] sel_data;

    assign sel_valid = (Grant[0] & Req0_Valid) | (Grant[1] & Req1_Valid);
    assign sel_data  = Grant[1] ? Req1_Data : Req0_Data;
    assign sel_last  = Grant[1] ? Req1_Last : Req0_Last;

`ifdef HDLC_TX_ARB_ABORT_EN
    assign sel_abort = (Grant[0] & Req0_Abort) | (Grant[1] & Req1_Abort);
`else
    logic abort_unused;
    assign abort_unused = Req0_Abort | Req1_Abort;
    assign sel_abort    = 1'b0;
`endif

    always_comb begin
        ready = 1'b0;
        case (state)
            LOAD:    ready = !Tx_Full && (count < MAX_CNT);
            DRAIN:   ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign Req0_Ready = Grant[0] & ready;
    assign Req1_Ready = Grant[1] & ready;
    assign hs         = sel_valid & ready;

    always_comb begin
        state_nxt    = state;
        grant_nxt    = Grant;
        ptr_nxt      = ptr;
        count_nxt    = count;
        data_nxt     = Tx_DataInBuff;
        wr_nxt       = 1'b0;
        en_nxt       = 1'b0;
        abort_nxt    = 1'b0;
        ovl_nxt      = 1'b0;
        low_seen_nxt = low_seen;
        case (state)
            IDLE: begin
                if (Req0_Valid || Req1_Valid) begin
                    // ptr names the preferred requester; the other wins only if it is idle
                    grant_nxt = (ptr ? !Req1_Valid : Req0_Valid) ? 2'b01 : 2'b10;
                    count_nxt = 8'd0;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (hs) begin
                    data_nxt  = sel_data;
                    wr_nxt    = 1'b1;
                    count_nxt = count + 8'd1;
                    if (sel_last) begin
                        state_nxt = START;
                    end else if (count + 8'd1 == MAX_CNT) begin
                        ovl_nxt   = 1'b1;
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (hs && sel_last) state_nxt = START;
            end
            START: begin
                en_nxt       = 1'b1;
                low_seen_nxt = 1'b0;
                state_nxt    = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!Tx_Done) begin
                    low_seen_nxt = 1'b1;
                end else if (low_seen) begin
                    grant_nxt = 2'b00;
                    ptr_nxt   = ~ptr;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A byte accepted in the abort cycle is still written; the frame is simply never started.
        if (state != IDLE && sel_abort) begin
            abort_nxt = 1'b1;
            en_nxt    = 1'b0;
            ovl_nxt   = 1'b0;
            grant_nxt = 2'b00;
            ptr_nxt   = ~ptr;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state         <= IDLE;
            Grant         <= 2'b00;
            ptr           <= 1'b0;
            count         <= 8'd0;
            Tx_DataInBuff <= 8'd0;
            Tx_WrBuff     <= 1'b0;
            Tx_Enable     <= 1'b0;
            Tx_AbortFrame <= 1'b0;
            Overlong      <= 1'b0;
            low_seen      <= 1'b0;
        end else begin
            state         <= state_nxt;
            Grant         <= grant_nxt;
            ptr           <= ptr_nxt;
            count         <= count_nxt;
            Tx_DataInBuff <= data_nxt;
            Tx_WrBuff     <= wr_nxt;
            Tx_Enable     <= en_nxt;
            Tx_AbortFrame <= abort_nxt;
            Overlong      <= ovl_nxt;
            low_seen      <= low_seen_nxt;
        end
    end
endmodule

// File: doc/hdlc_tx_arbiter.md
# hdlc_tx_arbiter

Shares the HDLC transmitter between two frame sources. Frames are transferred one at a time, with round-robin arbitration, from byte-stream requester ports into the Tx buffer. The block starts transmission with Tx_Enable and holds off the next grant until Tx_Done reports that the buffer has been drained. It sits between the system-side frame producers and the Tx buffer/Tx channel, in place of direct register writes.

## Interface
- MAX_FRAME, default 126: maximum bytes loaded per frame; matches the Tx buffer capacity before Tx_Full.
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous reset, active-low.
- Req0_Valid / Req1_Valid  in  1  requester has a byte on Data.
- Req0_Data / Req1_Data  in  8  frame byte.
- Req0_Last / Req1_Last  in  1  byte is the last of the frame.
- Req0_Abort / Req1_Abort  in  1  abort the requester's own frame (used only with the macro).
- Req0_Ready / Req1_Ready  out  1  byte accepted when Valid && Ready.
- Grant  out  2  one-hot owner of the Tx channel; 0 when idle.
- Tx_DataInBuff  out  8  byte to the Tx buffer.
- Tx_WrBuff  out  1  Tx buffer write strobe.
- Tx_Enable  out  1  one-cycle start-transmission pulse.
- Tx_AbortFrame  out  1  one-cycle abort pulse.
- Tx_Full  in  1  Tx buffer full.
- Tx_Done  in  1  Tx buffer fully read by the transmitter.
- Overlong  out  1  one-cycle pulse when a frame is truncated at MAX_FRAME.

## Operation
- The state machine has five states: IDLE, LOAD, DRAIN, START, WAIT_DONE.
- **IDLE**
  - If any Valid is high, grant per the round-robin pointer: the pointer names the preferred requester; the other wins only if the preferred one is not Valid.
  - Next: LOAD, with Grant set and the byte count cleared.
- **LOAD**
  - Ready of the granted requester = !Tx_Full && count < MAX_FRAME. Ready of the non-granted requester is always 0.
  - On each handshake: Tx_DataInBuff <= Data, Tx_WrBuff <= 1, count <= count+1 (8-bit, never exceeds MAX_FRAME).
  - Handshake with Last → START.
  - Handshake that makes count == MAX_FRAME without Last → pulse Overlong, go to DRAIN.
- **DRAIN**
  - Ready = 1, bytes are discarded (no Tx_WrBuff).
  - Handshake with Last → START. The truncated MAX_FRAME-byte frame is transmitted.
- **START**: wait one cycle, then pulse Tx_Enable and go to WAIT_DONE.
- **WAIT_DONE**
  - Completion is defined as Tx_Done sampled low at least once since Tx_Enable, followed by Tx_Done sampled high.
  - On completion: the pointer moves to the other requester, Grant <= 0, state → IDLE.
- Valid dropping mid-frame is legal: LOAD waits with no timeout.
- A single-byte frame (Last on the first byte) is legal.
- Tx_Full rising mid-frame stalls Ready; loading resumes when it falls.

## Timing
- Reset (asynchronous, Rst low):
  - All outputs 0; state IDLE; count 0; pointer selects Req0.
  - The Tx buffer contents are not touched.
  - A reset asserted mid-frame never produces Tx_Enable for the partial frame.
- Grant: Valid sampled high in IDLE at cycle t → Grant and LOAD at t+1 → first possible handshake at t+1.
- Ready depends combinationally on state, Grant, Tx_Full and count. Data, Last and Abort are not combinationally routed to outputs.
- Write: handshake at cycle t → Tx_WrBuff high and Tx_DataInBuff valid during t+1. Back-to-back handshakes give back-to-back writes.
- Start: Last handshake at t → START at t+1 → Tx_Enable high during t+2 only, when the last Tx_WrBuff has already completed.
- Release: Tx_Done high sampled at cycle d (after the low sample) → Grant 0 at d+1 → earliest next Grant at d+2.
- Simultaneous Valid on both requesters in IDLE → the pointer decides. Two consecutive frames therefore alternate 0, 1.

## Configuration
- HDLC_TX_ARB_ABORT_EN defined:
  - Granted requester's Abort sampled high in LOAD, DRAIN or START → Tx_AbortFrame pulse next cycle, no Tx_Enable, pointer advances, back to IDLE.
  - Abort in WAIT_DONE → Tx_AbortFrame pulse, then back to IDLE without waiting for Tx_Done.
  - Abort from the non-granted requester is ignored.
- HDLC_TX_ARB_ABORT_EN undefined: Req*_Abort are ignored and Tx_AbortFrame is tied 0.

## Test plan
- Req0 sends 3 bytes 0xA5, 0x7E, 0x01 (Last on 0x01), Tx_Done low then high 20 cycles later:
  - Three Tx_WrBuff pulses with those data values in order.
  - Tx_Enable pulses exactly 2 cycles after the 0x01 handshake; Grant returns to 0 one cycle after Tx_Done rises.
- Both Valid high from reset, 2-byte frames each: Grant 01 first, then 10, then 01 again; no frame interleaving on Tx_DataInBuff.
- Tx_Full forced high for 5 cycles mid-frame: Ready low for exactly those cycles, no Tx_WrBuff; all bytes delivered afterwards.
- 130-byte frame on Req1:
  - 126 Tx_WrBuff pulses and one Overlong pulse.
  - The last 4 bytes are accepted without a write.
  - Tx_Enable pulses after the byte with Last.
- Rst pulled low after 2 bytes loaded: all outputs 0 immediately; no Tx_Enable; Req0 is preferred at the next arbitration.
- With HDLC_TX_ARB_ABORT_EN, Req0_Abort during LOAD: Tx_AbortFrame high 1 cycle, no Tx_Enable, and the next pending Req1 frame is granted.
